// File: rtl/fft_pkg.sv
// Shared types and sizes for the fft8 family: complex bin payload, frame geometry, serializer states.
package fft_pkg;

  localparam int unsigned DW     = 24;
  localparam int unsigned NPOINT = 8;
  localparam int unsigned IDX_W  = 3;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/fft8_serializer_if.sv
// Bundle for fft8_serializer: parallel frame input, one-bin-per-beat output stream, drop monitor.
interface fft8_serializer_if #(
  parameter int unsigned DW    = fft_pkg::DW,
  parameter int unsigned CNT_W = 8
);
  import fft_pkg::*;

  logic                    valid;
  logic signed [DW-1:0]    y_real [NPOINT];
  logic signed [DW-1:0]    y_imag [NPOINT];

  logic                    out_valid;
  logic                    out_ready;
  logic signed [DW-1:0]    out_real;
  logic signed [DW-1:0]    out_imag;
  logic [IDX_W-1:0]        out_index;
  logic                    out_last;

  logic                    overflow;
  logic                    overflow_clr;
  logic [CNT_W-1:0]        drop_cnt;

  modport master (
    output valid, y_real, y_imag, out_ready, overflow_clr,
    input  out_valid, out_real, out_imag, out_index, out_last, overflow, drop_cnt
  );

  modport slave (
    input  valid, y_real, y_imag, out_ready, overflow_clr,
    output out_valid, out_real, out_imag, out_index, out_last, overflow, drop_cnt
  );

endinterface

// File: rtl/fft8_frame_buf.sv
// Two-slot frame store: writes a whole 8-bin frame in one cycle, reads one bin combinationally.
module fft8_frame_buf
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    we,
  input  logic                    wr_slot,
  input  cplx_t [NPOINT-1:0]      wr_frame,
  input  logic                    rd_slot,
  input  logic [IDX_W-1:0]        rd_idx,
  output cplx_t                   rd_bin_c
);

  cplx_t [NPOINT-1:0] mem [2];

  // Payload only; occupancy lives in the owner's full flags, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_slot] <= wr_frame;
    end
  end

  assign rd_bin_c = mem[rd_slot][rd_idx];

endmodule

// File: rtl/fft8_serializer.sv
// Captures 8-bin fft8 frames into a ping-pong buffer and streams them out one bin per beat.
module fft8_serializer
  import fft_pkg::*;
#(
  parameter int unsigned DW    = fft_pkg::DW,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  fft8_serializer_if.slave   bus
);

  localparam int unsigned      BIN_W    = $bits(cplx_t) / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

  state_t            state, state_nxt;
  logic [1:0]        full, full_nxt;
  logic              wr_ptr;
  logic              rd_ptr, rd_ptr_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;

  logic              beat_c, last_done_c, slot_free_c, capture_c, drop_c;
  cplx_t [NPOINT-1:0] frame_c;
  cplx_t             rd_bin_c;

  logic              out_valid_q, out_valid_nxt;
  logic signed [DW-1:0] out_real_q, out_real_nxt;
  logic signed [DW-1:0] out_imag_q, out_imag_nxt;
  logic [IDX_W-1:0]  out_index_q, out_index_nxt;
  logic              out_last_q, out_last_nxt;
  logic              overflow_q, overflow_nxt;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_nxt;

  always_comb begin
    for (int unsigned k = 0; k < NPOINT; k++) begin
      frame_c[k].re = BIN_W'(bus.y_real[k]);
      frame_c[k].im = BIN_W'(bus.y_imag[k]);
    end
  end

  fft8_frame_buf u_buf (
    .clk      (clk),
    .we       (capture_c),
    .wr_slot  (wr_ptr),
    .wr_frame (frame_c),
    .rd_slot  (rd_ptr_nxt),
    .rd_idx   (idx_nxt),
    .rd_bin_c (rd_bin_c)
  );

  assign beat_c      = out_valid_q && bus.out_ready;
  assign last_done_c = (state == STREAM) && beat_c && (idx == LAST_IDX);

  // A slot released by this cycle's final beat may be refilled in the same cycle.
  always_comb begin
    slot_free_c = !full[wr_ptr] || (last_done_c && (rd_ptr == wr_ptr));
    capture_c   = bus.valid && slot_free_c;
    drop_c      = bus.valid && !slot_free_c;
    full_nxt    = full;
    if (last_done_c) full_nxt[rd_ptr] = 1'b0;
    if (capture_c)   full_nxt[wr_ptr] = 1'b1;
  end

  // Clear first, then a coincident drop still counts as one.
  always_comb begin
    overflow_nxt = overflow_q;
    drop_cnt_nxt = drop_cnt_q;
    if (bus.overflow_clr) begin
      overflow_nxt = 1'b0;
      drop_cnt_nxt = '0;
    end
    if (drop_c) begin
      overflow_nxt = 1'b1;
      if (drop_cnt_nxt != '1) drop_cnt_nxt = drop_cnt_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Back-to-back only uses the other slot if it was already full before this edge.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    rd_ptr_nxt = rd_ptr;
    case (state)
      IDLE: begin
        if (full[rd_ptr]) state_nxt = STREAM;
      end
      STREAM: begin
        if (beat_c) begin
          if (idx == LAST_IDX) begin
            idx_nxt    = '0;
            rd_ptr_nxt = ~rd_ptr;
            if (!full[~rd_ptr]) state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid_nxt = (state_nxt == STREAM);
    out_index_nxt = '0;
    out_last_nxt  = 1'b0;
    out_real_nxt  = '0;
    out_imag_nxt  = '0;
    if (out_valid_nxt) begin
      out_index_nxt = idx_nxt;
      out_last_nxt  = (idx_nxt == LAST_IDX);
      out_real_nxt  = DW'(rd_bin_c.re);
      out_imag_nxt  = DW'(rd_bin_c.im);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      full        <= full_nxt;
      wr_ptr      <= wr_ptr ^ capture_c;
      rd_ptr      <= rd_ptr_nxt;
      idx         <= idx_nxt;
      out_valid_q <= out_valid_nxt;
      out_real_q  <= out_real_nxt;
      out_imag_q  <= out_imag_nxt;
      out_index_q <= out_index_nxt;
      out_last_q  <= out_last_nxt;
      overflow_q  <= overflow_nxt;
      drop_cnt_q  <= drop_cnt_nxt;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fft8_serializer.sv
// Directed bench for fft8_serializer: latency, backpressure, drops, same-cycle free/capture, saturation, reset.
module tb_fft8_serializer;
  import fft_pkg::*;

  localparam int unsigned W = fft_pkg::DW;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   k_seen;
  int   cyc;

  fft8_serializer_if #(.DW(W), .CNT_W(8)) ifc ();

  fft8_serializer #(.DW(W), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Frame tag t, bin k: real = 1000t + 10(k+1), imag = (k+1) - 1000t (tag 0 gives 10..80 / 1..8).
  function automatic logic [W-1:0] re_of(input int tag, input int k);
    return W'(tag * 1000 + 10 * (k + 1));
  endfunction

  function automatic logic [W-1:0] im_of(input int tag, input int k);
    return W'(k + 1 - tag * 1000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_frame(input int tag);
    for (int k = 0; k < 8; k++) begin
      ifc.y_real[k] = re_of(tag, k);
      ifc.y_imag[k] = im_of(tag, k);
    end
  endtask

  task automatic send(input int tag);
    drive_frame(tag);
    ifc.valid = 1'b1;
    tick();
    ifc.valid = 1'b0;
  endtask

  task automatic chk_beat(input int tag, input int k);
    chk($sformatf("f%0d_b%0d_valid", tag, k), W'(ifc.out_valid), W'(1));
    chk($sformatf("f%0d_b%0d_index", tag, k), W'(ifc.out_index), W'(k));
    chk($sformatf("f%0d_b%0d_real",  tag, k), ifc.out_real, re_of(tag, k));
    chk($sformatf("f%0d_b%0d_imag",  tag, k), ifc.out_imag, im_of(tag, k));
    chk($sformatf("f%0d_b%0d_last",  tag, k), W'(ifc.out_last), W'(k == 7));
  endtask

  // Expects 8 consecutive accepted beats of frame tag; inj >= 0 raises valid on the bin-7 handshake.
  task automatic beats(input int tag, input int inj);
    for (int k = 0; k < 8; k++) begin
      chk_beat(tag, k);
      if (k == 7 && inj >= 0) begin
        drive_frame(inj);
        ifc.valid = 1'b1;
      end
      tick();
      ifc.valid = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},    W'(ifc.out_valid), W'(0));
    chk({tag, "_real"},     ifc.out_real,      W'(0));
    chk({tag, "_imag"},     ifc.out_imag,      W'(0));
    chk({tag, "_index"},    W'(ifc.out_index), W'(0));
    chk({tag, "_last"},     W'(ifc.out_last),  W'(0));
    chk({tag, "_overflow"}, W'(ifc.overflow),  W'(0));
    chk({tag, "_drop_cnt"}, W'(ifc.drop_cnt),  W'(0));
  endtask

  initial begin
    rst              = 1'b1;
    ifc.valid        = 1'b0;
    ifc.out_ready    = 1'b0;
    ifc.overflow_clr = 1'b0;
    drive_frame(0);
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // Single frame, ready high: bin 0 one cycle after capture, then 8 beats, then idle.
    ifc.out_ready = 1'b1;
    send(0);
    chk("t1_capture_cycle_idle", W'(ifc.out_valid), W'(0));
    tick();
    beats(0, -1);
    chk("t1_idle_after", W'(ifc.out_valid), W'(0));

    // Backpressure with ready pattern 1,0,0,1,0,0,...
    ifc.out_ready = 1'b0;
    send(1);
    k_seen = 0;
    cyc    = 0;
    while (k_seen < 8 && cyc < 40) begin
      tick();
      chk_beat(1, k_seen);
      ifc.out_ready = ((cyc % 3) == 0);
      if (ifc.out_valid && ifc.out_ready) k_seen++;
      cyc++;
    end
    chk("t2_beats_accepted", W'(k_seen), W'(8));
    tick();
    chk("t2_idle_after", W'(ifc.out_valid), W'(0));

    // Three back-to-back frames with ready low: third is dropped.
    ifc.out_ready = 1'b0;
    send(2);
    send(3);
    send(4);
    chk("t3_overflow", W'(ifc.overflow), W'(1));
    chk("t3_drop_cnt", W'(ifc.drop_cnt), W'(1));
    ifc.out_ready = 1'b1;
    beats(2, -1);
    beats(3, -1);
    chk("t3_idle_after", W'(ifc.out_valid), W'(0));
    chk("t3_drop_cnt_kept", W'(ifc.drop_cnt), W'(1));

    // Both slots full; a new frame arrives on the bin-7 handshake and must be kept.
    ifc.out_ready = 1'b0;
    send(5);
    send(6);
    ifc.out_ready = 1'b1;
    beats(5, 7);
    beats(6, -1);
    beats(7, -1);
    chk("t4_idle_after", W'(ifc.out_valid), W'(0));
    chk("t4_drop_cnt_unchanged", W'(ifc.drop_cnt), W'(1));

    // Clear, then 300 forced drops with saturation, then clear coinciding with a drop.
    ifc.overflow_clr = 1'b1;
    tick();
    ifc.overflow_clr = 1'b0;
    chk("t5_clr_overflow", W'(ifc.overflow), W'(0));
    chk("t5_clr_drop_cnt", W'(ifc.drop_cnt), W'(0));
    ifc.out_ready = 1'b0;
    send(8);
    send(9);
    drive_frame(10);
    ifc.valid = 1'b1;
    repeat (254) tick();
    chk("t5_drop_254", W'(ifc.drop_cnt), W'(254));
    tick();
    chk("t5_drop_255", W'(ifc.drop_cnt), W'(255));
    repeat (45) tick();
    chk("t5_drop_sat", W'(ifc.drop_cnt), W'(255));
    chk("t5_overflow", W'(ifc.overflow), W'(1));
    ifc.overflow_clr = 1'b1;
    tick();
    ifc.valid        = 1'b0;
    ifc.overflow_clr = 1'b0;
    chk("t5_clr_with_drop_cnt", W'(ifc.drop_cnt), W'(1));
    chk("t5_clr_with_drop_ovf", W'(ifc.overflow), W'(1));

    // Reset at beat 3 with both slots full: everything discarded.
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_beat(8, k);
      tick();
    end
    chk_beat(8, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("t6_reset");
    repeat (12) tick();
    chk("t6_no_beats", W'(ifc.out_valid), W'(0));
    send(11);
    chk("t6_capture_cycle_idle", W'(ifc.out_valid), W'(0));
    tick();
    beats(11, -1);
    chk("t6_idle_after", W'(ifc.out_valid), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft8_serializer.md
# fft8_serializer

Output-side companion to `fft8`. It captures the eight parallel complex bins from one `valid` pulse into a two-frame ping-pong buffer. It then streams them out one bin per beat, index 0..7, over a valid/ready interface. Downstream logic such as magnitude, feature extraction or host FIFOs sees a narrow sample stream instead of 16 wide buses. Frames that arrive while both buffers are occupied are dropped and counted.

## Interface
Parameters:
- `DW`, 24: width of each real/imag component; matches `fft8` output width.
- `CNT_W`, 8: width of the saturating drop counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid`  in  1  one-cycle frame strobe from `fft8`.
- `y0_real`..`y7_real`  in  DW each  signed real part of bins 0..7.
- `y0_imag`..`y7_imag`  in  DW each  signed imag part of bins 0..7.
- `out_valid`  out  1  current beat is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_real`, `out_imag`  out  DW  signed bin value.
- `out_index`  out  3  bin number of the current beat.
- `out_last`  out  1  high on the beat with `out_index` = 7.
- `overflow`  out  1  sticky: at least one frame dropped since reset or clear.
- `overflow_clr`  in  1  clears `overflow` and `drop_cnt`.
- `drop_cnt`  out  CNT_W  number of dropped frames, saturating at all-ones.

## Operation
- Storage:
  - Two frame slots, each holding 8 × (real, imag).
  - Per-slot `full` flag, 1-bit `wr_ptr`, 1-bit `rd_ptr`, 3-bit beat counter `idx`.
- Capture:
  - Fires when `valid` is high and slot `wr_ptr` is not full, or when it is full but is being freed this cycle.
  - The whole frame is written in that one cycle, that slot's `full` is set and `wr_ptr` toggles.
  - Bins are stored unmodified with no scaling or reordering.
- Drop:
  - Occurs when `valid` is high and no slot is available.
  - Frame is discarded and `overflow` is set.
  - `drop_cnt` increments and saturates.
  - Buffer contents and pointers are unchanged.
- Read FSM:
  - IDLE: `out_valid`=0. Moves to STREAM when slot `rd_ptr` is full.
  - STREAM: presents bin `idx` of slot `rd_ptr`. The beat completes on `out_valid && out_ready`, and `idx` increments.
  - On the completing beat with `idx`=7, `idx` returns to 0, the slot's `full` flag clears and `rd_ptr` toggles.
  - After that beat the FSM stays in STREAM if the other slot is full; otherwise it returns to IDLE.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_real`, `out_imag`, `out_index` and `out_last` hold stable.
- Simultaneous events:
  - A last-beat handshake and a capture into the same slot in one cycle are legal. The free takes effect first, so no drop occurs.
  - `overflow_clr` coinciding with a drop leaves `overflow`=1 and `drop_cnt`=1.

## Timing
- Reset: in the cycle after `rst`=1 is sampled:
  - `out_valid`=0, `out_real`=`out_imag`=0, `out_index`=0, `out_last`=0, `overflow`=0, `drop_cnt`=0.
  - Both slots empty, both pointers 0, FSM in IDLE.
- Reset mid-stream: the frame in flight and any buffered frame are discarded with no partial completion.
- Latency: a frame captured at edge N gives `out_valid`=1 with bin 0 from edge N+1 when the buffer was empty.
- Throughput: with `out_ready` held high, 8 beats are output per frame back-to-back. Consecutive frames stream with no bubble between bin 7 and the next bin 0.
- Sustained input: `valid` every 8 cycles is sustainable with zero drops when `out_ready`=1.
- Outputs are registered. Backpressure is a handshake on `out_valid`/`out_ready`; there is no path from `out_ready` to `out_valid`.

## Structure
- Shared package `fft_pkg`:
  - `DW` default.
  - `cplx_t` packed struct {signed real, signed imag}.
  - `NPOINT`=8 and `IDX_W`=3.
  - FSM state enum {IDLE, STREAM}.
- Sub-module `fft8_frame_buf`: the two-slot register array with write-whole-frame / read-one-bin ports.
- The top level holds the pointers, full flags, FSM and counters.

## Test plan
- Single frame with real = 10,20,…,80 and imag = 1..8, and `out_ready`=1:
  - Beats 0..7 appear on cycles N+1..N+8 with exact values.
  - `out_last` is high only on index 7, then `out_valid`=0.
- Backpressure: `out_ready` toggles 1,0,0,1,… during one frame. Each bin is held while ready is low, and all 8 bins arrive in order with none repeated or lost.
- Three `valid` pulses on consecutive cycles with `out_ready`=0:
  - The third frame is dropped, `overflow`=1, `drop_cnt`=1.
  - After `out_ready`=1, only frames 1 and 2 are output (16 beats).
- Both slots full, and a new `valid` coincides with the bin 7 handshake: the frame is captured, `drop_cnt` is unchanged, and 24 beats are eventually output.
- `overflow_clr` pulse, then 300 forced drops: `drop_cnt` saturates at 255; a `clr` coinciding with a drop gives `drop_cnt`=1.
- `rst` asserted at beat 3 with both slots full: the next cycle shows all outputs at zero, and no beats follow until a new `valid`.
